minsum_scan_ctrl: RTL and testbench

- Sequences one check-node min-sum update over a serial message store: pass 1 finds min1, its index and the sign product; pass 2 re-reads every position except min1_idx to find min2.
- Sits between the check-node message RAM (read port, 1-cycle latency) and the check-node output register stage of the belief-propagation decoder.
- Owns address generation, the skip-index rule, and the start/busy/done handshake.

---
 rtl/minsum_pkg.sv | 20 ++
 rtl/minsum_scan_ctrl_skip_addr_counter.sv | 48 ++++
 rtl/minsum_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_minsum_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/minsum_pkg.sv
// Shared types and helpers for the min-sum check-node scan controller.
package minsum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_e;

    // All-ones magnitude used to preload the running minimum registers.
    function automatic int unsigned mag_max(input int unsigned mag_w);
        return (32'd1 << mag_w) - 32'd1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned deg);
        return (deg > 1) ? $clog2(deg) : 1;
    endfunction

endpackage

// File: rtl/minsum_scan_ctrl_skip_addr_counter.sv
// Read-address counter that steps over one excluded index and flags the last address.
module skip_addr_counter #(
    parameter int unsigned DEG   = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_skip_en,
    input  logic [IDX_W-1:0] i_skip_idx,
    output logic [IDX_W-1:0] o_count,
    output logic             o_last_c
);

    localparam logic [IDX_W-1:0] LAST      = IDX_W'(DEG - 1);
    localparam logic [IDX_W-1:0] NEXT_LAST = IDX_W'(DEG - 2);

    logic [IDX_W-1:0] r_count;
    logic [IDX_W-1:0] w_first;
    logic [IDX_W-1:0] w_inc1;
    logic [IDX_W-1:0] w_next;

    // Wrap of w_inc1 only happens past the last address, where the counter never advances.
    always_comb begin
        w_first  = (i_skip_en && (i_skip_idx == '0)) ? IDX_W'(1) : '0;
        w_inc1   = r_count + IDX_W'(1);
        w_next   = w_inc1;
        if (i_skip_en && (w_inc1 == i_skip_idx)) begin
            w_next = w_inc1 + IDX_W'(1);
        end
        o_last_c = (r_count == LAST) ||
                   (i_skip_en && (i_skip_idx == LAST) && (r_count == NEXT_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= w_first;
        end else if (i_en) begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/minsum_scan_ctrl.sv
// Two-pass min-sum check-node scan: pass 1 finds min1/index/sign product, pass 2 finds min2.
module minsum_scan_ctrl
    import minsum_pkg::*;
#(
    parameter int unsigned DEG   = 4,
    parameter int unsigned MAG_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [idx_w(DEG)-1:0] rd_addr,
    input  logic [MAG_W:0]        rd_data,
    output logic [MAG_W-1:0]      min1,
    output logic [MAG_W-1:0]      min2,
    output logic [idx_w(DEG)-1:0] min1_idx,
    output logic                  sign_prod
);

    localparam int unsigned      IDX_W    = idx_w(DEG);
    localparam logic [MAG_W-1:0] MAG_ONES = MAG_W'(mag_max(MAG_W));

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_rd_en;
    logic               r_rd_vld;
    logic [IDX_W-1:0]   r_vld_idx;
    logic [MAG_W-1:0]   r_wk_min1;
    logic [MAG_W-1:0]   r_wk_min2;
    logic [IDX_W-1:0]   r_wk_idx;
    logic               r_wk_sign;

    logic               w_rd_en_nxt;
    logic               w_load;
    logic               w_adv;
    logic               w_init;
    logic               w_skip_en;
    logic               w_last;
    logic [IDX_W-1:0]   w_addr;
    logic               w_sign;
    logic [MAG_W-1:0]   w_mag;
    logic               w_p1_hit;
    logic [IDX_W-1:0]   w_idx_nxt;

    assign w_sign = rd_data[MAG_W];
    assign w_mag  = rd_data[MAG_W-1:0];

    // The pass-1 drain word may still move min1, so the skip index is taken pre-register.
    always_comb begin
        w_p1_hit  = (r_state == PASS1) && r_rd_vld && (w_mag < r_wk_min1);
        w_idx_nxt = w_p1_hit ? r_vld_idx : r_wk_idx;
        w_skip_en = (r_state == PASS2) || ((r_state == PASS1) && !r_rd_en);
    end

    skip_addr_counter #(
        .DEG   (DEG),
        .IDX_W (IDX_W)
    ) u_addr (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_en       (w_adv),
        .i_skip_en  (w_skip_en),
        .i_skip_idx (w_idx_nxt),
        .o_count    (w_addr),
        .o_last_c   (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en_nxt = 1'b0;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_init      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = PASS1;
                    w_load      = 1'b1;
                    w_rd_en_nxt = 1'b1;
                    w_init      = 1'b1;
                end
            end
            PASS1: begin
                if (r_rd_en) begin
                    if (!w_last) begin
                        w_adv       = 1'b1;
                        w_rd_en_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = PASS2;
                    w_load      = 1'b1;
                    w_rd_en_nxt = 1'b1;
                end
            end
            PASS2: begin
                if (r_rd_en) begin
                    if (!w_last) begin
                        w_adv       = 1'b1;
                        w_rd_en_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_rd_en   <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_vld_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_vld  <= r_rd_en;
            r_vld_idx <= w_addr;
            busy      <= (w_state_nxt == PASS1) || (w_state_nxt == PASS2);
            done      <= (r_state == DONE);
        end
    end

    // Running minima and sign accumulator, fed one cycle behind the read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wk_min1 <= '0;
            r_wk_min2 <= '0;
            r_wk_idx  <= '0;
            r_wk_sign <= 1'b0;
        end else if (w_init) begin
            r_wk_min1 <= MAG_ONES;
            r_wk_min2 <= MAG_ONES;
            r_wk_idx  <= '0;
            r_wk_sign <= 1'b0;
        end else if (r_rd_vld) begin
            if (r_state == PASS1) begin
                r_wk_sign <= r_wk_sign ^ w_sign;
                if (w_p1_hit) begin
                    r_wk_min1 <= w_mag;
                    r_wk_idx  <= r_vld_idx;
                end
            end else if ((r_state == PASS2) && (w_mag < r_wk_min2)) begin
                r_wk_min2 <= w_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min1      <= '0;
            min2      <= '0;
            min1_idx  <= '0;
            sign_prod <= 1'b0;
        end else if (r_state == DONE) begin
            min1      <= r_wk_min1;
            min2      <= r_wk_min2;
            min1_idx  <= r_wk_idx;
            sign_prod <= r_wk_sign;
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = w_addr;

endmodule

// File: tb/tb_minsum_scan_ctrl.sv
// Scoreboard bench for minsum_scan_ctrl: directed vectors plus random message sets.
module tb_minsum_scan_ctrl;

    localparam int unsigned DEG   = 4;
    localparam int unsigned MAG_W = 4;
    localparam int unsigned IDX_W = $clog2(DEG);

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             start   = 1'b0;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [MAG_W:0]   rd_data = '0;
    logic [MAG_W-1:0] min1;
    logic [MAG_W-1:0] min2;
    logic [IDX_W-1:0] min1_idx;
    logic             sign_prod;

    logic [MAG_W:0]   mem [DEG];

    typedef struct {
        int min1;
        int min2;
        int idx;
        int sgn;
        int t0;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   got_addr[$];
    int   busy_cnt = 0;

    minsum_scan_ctrl #(
        .DEG   (DEG),
        .MAG_W (MAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .min1      (min1),
        .min2      (min2),
        .min1_idx  (min1_idx),
        .sign_prod (sign_prod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Message RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: min1 = smallest value, idx = its first position, min2 = smallest elsewhere.
    function automatic exp_t ref_model();
        exp_t e;
        int   mags[DEG];
        int   lo;
        e.sgn = 0;
        lo    = 1 << MAG_W;
        for (int i = 0; i < DEG; i++) begin
            mags[i] = int'(mem[i][MAG_W-1:0]);
            e.sgn   = e.sgn ^ int'(mem[i][MAG_W]);
            if (mags[i] < lo) lo = mags[i];
        end
        e.min1 = lo;
        e.idx  = -1;
        for (int i = 0; i < DEG; i++) begin
            if (e.idx < 0 && mags[i] == lo) e.idx = i;
        end
        e.min2 = 1 << MAG_W;
        for (int i = 0; i < DEG; i++) begin
            if (i != e.idx && mags[i] < e.min2) e.min2 = mags[i];
        end
        e.t0 = 0;
        return e;
    endfunction

    task automatic set_vec(input int s0, m0, s1, m1, s2, m2, s3, m3);
        mem[0] = {1'(s0), MAG_W'(m0)};
        mem[1] = {1'(s1), MAG_W'(m1)};
        mem[2] = {1'(s2), MAG_W'(m2)};
        mem[3] = {1'(s3), MAG_W'(m3)};
    endtask

    task automatic issue_start();
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e    = ref_model();
        e.t0 = cyc;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Monitor: collects the read stream and busy cycles, scores each done pulse.
    always @(negedge clk) begin
        exp_t e;
        int   exp_addr[$];
        if (!reset) begin
            got_addr.delete();
            busy_cnt = 0;
        end else begin
            if (rd_en) got_addr.push_back(int'(rd_addr));
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("min1", int'(min1), e.min1);
                    check("min2", int'(min2), e.min2);
                    check("min1_idx", int'(min1_idx), e.idx);
                    check("sign_prod", int'(sign_prod), e.sgn);
                    check("latency", cyc - e.t0, 2 * DEG + 2);
                    check("busy_cycles", busy_cnt, 2 * DEG + 1);
                    exp_addr.delete();
                    for (int i = 0; i < DEG; i++) exp_addr.push_back(i);
                    for (int i = 0; i < DEG; i++) if (i != e.idx) exp_addr.push_back(i);
                    check("rd_count", got_addr.size(), exp_addr.size());
                    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
                        check("rd_addr", got_addr[i], exp_addr[i]);
                    end
                end
                got_addr.delete();
                busy_cnt = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < DEG; i++) mem[i] = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_min1", int'(min1), 0);
        check("rst_min2", int'(min2), 0);
        check("rst_min1_idx", int'(min1_idx), 0);
        check("rst_sign_prod", int'(sign_prod), 0);
        @(negedge clk);
        reset = 1'b1;

        set_vec(0, 5, 1, 2, 1, 7, 0, 3);   issue_start(); wait_idle();
        set_vec(0, 1, 0, 6, 0, 4, 0, 9);   issue_start(); wait_idle();
        set_vec(1, 3, 0, 3, 0, 8, 0, 3);   issue_start(); wait_idle();
        set_vec(0, 9, 0, 8, 1, 7, 1, 0);   issue_start(); wait_idle();
        set_vec(0, 15, 0, 15, 0, 15, 0, 15); issue_start(); wait_idle();

        // Second start pulse mid-scan must not produce another done.
        set_vec(0, 5, 1, 2, 1, 7, 0, 3);
        issue_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);

        // Asynchronous reset during pass 2 clears everything at once.
        set_vec(0, 9, 0, 8, 1, 7, 1, 0);
        issue_start();
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        q.delete();
        check("abort_busy", int'(busy), 0);
        check("abort_rd_en", int'(rd_en), 0);
        check("abort_rd_addr", int'(rd_addr), 0);
        check("abort_min1", int'(min1), 0);
        check("abort_min2", int'(min2), 0);
        check("abort_min1_idx", int'(min1_idx), 0);
        check("abort_sign_prod", int'(sign_prod), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set_vec(0, 5, 1, 2, 1, 7, 0, 3);   issue_start(); wait_idle();

        for (int t = 0; t < 60; t++) begin
            int hi;
            hi = ($urandom_range(0, 1) != 0) ? 15 : 3;
            for (int i = 0; i < DEG; i++) begin
                mem[i] = {1'($urandom_range(0, 1)), MAG_W'($urandom_range(0, hi))};
            end
            issue_start();
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
